// File: rtl/regwr_decode_sb.sv
// Writeback destination decoder with a pipelined one-hot write-enable
// output and a per-register pending-write scoreboard for hazard checks.
module regwr_decode_sb #(
  parameter int ADDR_W         = 5,
  parameter bit ZERO_HARDWIRED = 1'b1,
  parameter int WE_STAGES      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_dst,
  output logic                       iss_ready,
  input  logic [ADDR_W-1:0]          rs_addr,
  input  logic [ADDR_W-1:0]          rt_addr,
  output logic                       rs_busy,
  output logic                       rt_busy,
  output logic [(1<<ADDR_W)-1:0]     we_onehot,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic [ADDR_W:0]            pending_cnt,
  output logic                       err_spurious
);

  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = ADDR_W + 1;
  localparam logic [NREG-1:0] ONE = NREG'(1);

  logic [NREG-1:0] pipe_q [WE_STAGES];
  logic [NREG-1:0] dec_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_vec, clr_vec;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            zero_wr, zero_iss;
  logic            set_ok, clr_ok;
  logic            set_inc, clr_dec;
  logic            rs_zero, rt_zero;

  assign zero_wr  = ZERO_HARDWIRED && (wr_addr == '0);
  assign zero_iss = ZERO_HARDWIRED && (iss_dst == '0);
  assign rs_zero  = ZERO_HARDWIRED && (rs_addr == '0);
  assign rt_zero  = ZERO_HARDWIRED && (rt_addr == '0);

  // Writes hitting register 0 decode to nothing when it is hardwired.
  assign dec_d = (wr_en && !zero_wr) ? (ONE << wr_addr) : '0;

  // A same-cycle writeback to the destination lifts a WAW stall.
  assign iss_ready = !busy_q[iss_dst]
                   || (wr_en && (wr_addr == iss_dst))
                   || zero_iss;

  assign set_ok  = iss_valid && iss_ready && !zero_iss;
  assign clr_ok  = wr_en && !zero_wr;
  assign set_vec = set_ok ? (ONE << iss_dst) : '0;
  assign clr_vec = clr_ok ? (ONE << wr_addr) : '0;

  // Set is applied after clear so a same-edge set wins.
  assign busy_d = (busy_q & ~clr_vec) | set_vec;

  // Count only real 0->1 and 1->0 transitions so the count tracks popcount.
  assign set_inc = set_ok && !busy_q[iss_dst];
  assign clr_dec = clr_ok && busy_q[wr_addr]
                 && !(set_ok && (iss_dst == wr_addr));
  assign cnt_d   = cnt_q + CW'(set_inc) - CW'(clr_dec);

  assign err_d = err_q || (clr_ok && !busy_q[wr_addr]);

  // Decode pipe: stage 0 samples the decode, later stages shift it along.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WE_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= dec_d;
      for (int i = 1; i < WE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Scoreboard bits, pending count and sticky spurious-write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign we_onehot    = pipe_q[WE_STAGES-1];
  assign busy         = busy_q;
  assign pending_cnt  = cnt_q;
  assign err_spurious = err_q;
  assign rs_busy      = busy_q[rs_addr] && !rs_zero;
  assign rt_busy      = busy_q[rt_addr] && !rt_zero;

endmodule

// File: doc/regwr_decode_sb.md
Name: regwr_decode_sb

Overview:
Parametrised successor to the register-file write-address decoder. It decodes the writeback destination into a registered, optionally pipelined one-hot write-enable vector, with register 0 suppression. It also keeps a per-register pending-write scoreboard: issue sets a bit and writeback clears it. It sits between ID/EX issue and WB and drives the register-file write enables and the hazard/stall logic.

Parameters:
ADDR_W, 5, register address width; NREG = 2**ADDR_W (derived, not overridable)
ZERO_HARDWIRED, 1, 1 = register 0 never written and never marked busy; 0 = register 0 treated like any other register
WE_STAGES, 1, latency from wr_en/wr_addr sample to we_onehot; legal range 1..4

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
wr_en  in  1  writeback write request
wr_addr  in  ADDR_W  writeback destination register
iss_valid  in  1  issue of an instruction that writes iss_dst
iss_dst  in  ADDR_W  destination of the issuing instruction
iss_ready  out  1  combinational; issue accepted when iss_valid && iss_ready
rs_addr  in  ADDR_W  source operand A address
rt_addr  in  ADDR_W  source operand B address
rs_busy  out  1  combinational; busy[rs_addr]
rt_busy  out  1  combinational; busy[rt_addr]
we_onehot  out  NREG  registered one-hot register-file write enables
busy  out  NREG  registered pending-write bits
pending_cnt  out  ADDR_W+1  number of set busy bits
err_spurious  out  1  sticky flag: writeback to a non-busy register

Behaviour:
- Reset: one clock, synchronous active-high; reset is sampled on the rising edge of clk. While reset is high: we_onehot, every pipeline stage, busy, pending_cnt and err_spurious are all 0. Reset overrides every same-cycle input.
- Decode pipe:
  - Stage 0 captures dec = (wr_en && !(ZERO_HARDWIRED && wr_addr==0)) ? (1 << wr_addr) : 0.
  - we_onehot is stage WE_STAGES-1, so wr_en sampled at edge N appears on we_onehot after edge N+WE_STAGES-1.
  - we_onehot is never more than one-hot; it is all-zero when no write is active.
  - Asserting reset mid-pipe flushes all stages; no enable emerges afterwards.
- Scoreboard set: on an edge with iss_valid && iss_ready, busy[iss_dst] <= 1. Not applied when ZERO_HARDWIRED && iss_dst==0.
- Scoreboard clear: on an edge with wr_en, busy[wr_addr] <= 0. Not applied for register 0 when ZERO_HARDWIRED.
- iss_ready = !busy[iss_dst] || (wr_en && wr_addr==iss_dst) || (ZERO_HARDWIRED && iss_dst==0).
  - A write-after-write to a still-pending register stalls.
  - Bypass case: a same-cycle writeback to the same register releases the stall.
- Same register set and cleared on the same edge: set wins, bit stays 1, pending_cnt is unchanged.
- pending_cnt next value = pending_cnt + set_applied - clear_applied.
  - clear_applied = 1 only if the bit was 1 and is not re-set on that edge.
  - Range is 0..NREG; pending_cnt never wraps.
  - pending_cnt always equals popcount(busy). This is a required invariant.
- Spurious write: wr_en to a register whose busy bit is 0 (excluding register 0 when ZERO_HARDWIRED):
  - the decode still proceeds;
  - busy is unchanged;
  - err_spurious <= 1 and stays 1 until reset.
- rs_busy/rt_busy reflect the registered busy state only. A writeback in the current cycle does not clear them until the next edge. With ZERO_HARDWIRED, address 0 always reads 0.
- No X on any output after reset for any input sequence.

Test Plan:
1. Reset, then wr_en=1, wr_addr=5, WE_STAGES=1 -> one edge later we_onehot=32'h0000_0020; with wr_en=0 on the next edge -> we_onehot=0. Repeat with WE_STAGES=3 -> the enable appears exactly 2 edges later than with WE_STAGES=1.
2. ZERO_HARDWIRED=1: wr_addr=0 with wr_en=1 -> we_onehot stays 0. iss_dst=0 -> iss_ready=1, busy unchanged, err_spurious stays 0.
3. Issue to register 8 -> busy[8]=1, pending_cnt=1, rs_addr=8 gives rs_busy=1. A second issue to 8 -> iss_ready=0, no change. Writeback to 8 -> next edge busy[8]=0, pending_cnt=0.
4. busy[9]=1, then iss_dst=9 issued together with wr_en to 9 on the same edge -> iss_ready=1, busy[9] stays 1, pending_cnt stays 1, we_onehot[9] pulses.
5. Issue all of registers 1..31 -> pending_cnt=31, and pending_cnt==popcount(busy) holds every cycle. Random issue/writeback for 10k cycles -> invariant holds throughout.
6. wr_en to register 12 while busy[12]=0 -> err_spurious=1 and stays 1. Reset asserted with a write in flight at WE_STAGES=4 -> all outputs 0, and no late enable after reset is released.
